// File: rtl/jtdd_vcap_pkg.sv
// Shared types and helpers for the jtdd_vcap video capture receiver.
// Holds the drain FSM states, the FIFO entry geometry, pixel packing and the CRC-16/CCITT step.
package jtdd_vcap_pkg;

    localparam int VCAP_AW      = 16;
    localparam int VCAP_DEPTH   = 8;
    localparam int DATA_W       = 16;
    localparam int VCAP_ENTRY_W = VCAP_AW + DATA_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WR   = 1'b1
    } drain_state_t;

    function automatic logic [DATA_W-1:0] pack_pixel(input logic [3:0] r,
                                                     input logic [3:0] g,
                                                     input logic [3:0] b);
        return {4'h0, r, g, b};
    endfunction

    // One 16-bit word, MSB first, poly 0x1021.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/jtdd_vcap_fifo.sv
// Synchronous FIFO buffering captured {address,data} entries ahead of the frame-buffer port.
// Pointers carry one extra wrap bit to tell full from empty; push while full is ignored.
module jtdd_vcap_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW:0]  r_wptr;
    logic [PW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[PW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/jtdd_vcap.sv
// Video capture receiver: buffers active pixels and writes them to a frame buffer over req/ack,
// and measures line length / frame height. Optional frame CRC with macro JTDD_VCAP_CRC_EN.
module jtdd_vcap
    import jtdd_vcap_pkg::*;
#(
    parameter int AW    = VCAP_AW,
    parameter int DEPTH = VCAP_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic          HS,
    input  logic          VS,
    input  logic [3:0]    red,
    input  logic [3:0]    green,
    input  logic [3:0]    blue,
    input  logic          cap_en,
    output logic [AW-1:0] fb_addr,
    output logic [15:0]   fb_din,
    output logic          fb_we,
    input  logic          fb_ok,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf,
    output logic [8:0]    hlen,
    output logic [8:0]    vlen,
    output logic [15:0]   crc
);

    localparam int EW = AW + DATA_W;

    logic          r_lhbl, r_lvbl, r_hs, r_vs;
    logic          w_lhbl_rise, w_lvbl_rise, w_lvbl_fall, w_hs_rise, w_vs_rise;
    logic          r_armed, r_pending, r_first, r_ovf, r_frame_done;
    logic [7:0]    r_vline, w_vline;
    logic [8:0]    r_hcol, w_hcol;
    logic          w_acc, w_push, w_drop, w_pop, w_done;
    logic          w_full, w_empty;
    logic [EW-1:0] w_entry, w_fifo_q;
    logic [AW-1:0] r_fb_addr;
    logic [15:0]   r_fb_din;
    logic          r_fb_we;
    logic [8:0]    r_hcnt, r_vcnt, r_hlen, r_vlen;
    drain_state_t  r_state, w_state_nx;

    assign w_lhbl_rise = pxl_cen & LHBL & ~r_lhbl;
    assign w_lvbl_rise = pxl_cen & LVBL & ~r_lvbl;
    assign w_lvbl_fall = pxl_cen & ~LVBL & r_lvbl;
    assign w_hs_rise   = pxl_cen & HS & ~r_hs;
    assign w_vs_rise   = pxl_cen & VS & ~r_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_lhbl, r_lvbl, r_hs, r_vs} <= '0;
        end else if (pxl_cen) begin
            {r_lhbl, r_lvbl, r_hs, r_vs} <= {LHBL, LVBL, HS, VS};
        end
    end

    // Effective column/line for this pixel, so a pixel coinciding with a line start uses column 0.
    assign w_hcol  = w_lhbl_rise ? 9'd0 : r_hcol;
    assign w_vline = w_lvbl_rise ? 8'd0 :
                     (w_lhbl_rise & ~r_first) ? r_vline + 8'd1 : r_vline;

    assign w_acc   = pxl_cen & LHBL & LVBL & r_armed;
    assign w_push  = w_acc & ~w_full & ~w_hcol[8];
    assign w_drop  = w_acc & ~w_push;
    assign w_entry = {AW'({w_vline, w_hcol[7:0]}), pack_pixel(red, green, blue)};
    assign w_done  = r_pending & w_empty & (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vline      <= '0;
            r_hcol       <= '0;
            r_first      <= 1'b0;
            r_armed      <= 1'b0;
            r_pending    <= 1'b0;
            r_ovf        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (pxl_cen) begin
                r_vline <= w_vline;
                r_hcol  <= (w_acc && !w_hcol[8]) ? w_hcol + 9'd1 : w_hcol;
                if (w_lvbl_rise)      r_first <= ~w_lhbl_rise;
                else if (w_lhbl_rise) r_first <= 1'b0;
            end
            if (w_lvbl_rise) begin
                r_armed <= cap_en;
                r_ovf   <= 1'b0;
            end else if (w_lvbl_fall && r_armed) begin
                r_armed <= 1'b0;
            end
            if (w_drop) r_ovf <= 1'b1;
            if (w_lvbl_fall && r_armed) r_pending <= 1'b1;
            else if (w_done)            r_pending <= 1'b0;
            r_frame_done <= w_done;
        end
    end

    jtdd_vcap_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = ST_WR;
                end
            end
            ST_WR: begin
                if (fb_ok) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Address/data are only loaded on a pop, so they stay frozen for the whole request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_addr <= '0;
            r_fb_din  <= '0;
            r_fb_we   <= 1'b0;
        end else if (w_pop) begin
            {r_fb_addr, r_fb_din} <= w_fifo_q;
            r_fb_we               <= 1'b1;
        end else if (r_state == ST_WR && fb_ok) begin
            r_fb_we <= 1'b0;
        end
    end

    // A VS edge that lands on an HS edge counts that line toward the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hlen <= '0;
            r_vlen <= '0;
        end else begin
            if (w_hs_rise) begin
                r_hlen <= r_hcnt;
                r_hcnt <= 9'd1;
            end else if (pxl_cen && r_hcnt != 9'h1FF) begin
                r_hcnt <= r_hcnt + 9'd1;
            end
            if (w_vs_rise) begin
                r_vlen <= r_vcnt;
                r_vcnt <= {8'd0, w_hs_rise};
            end else if (w_hs_rise && r_vcnt != 9'h1FF) begin
                r_vcnt <= r_vcnt + 9'd1;
            end
        end
    end

`ifdef JTDD_VCAP_CRC_EN
    logic [15:0] r_crc_acc;
    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_acc <= 16'hFFFF;
            r_crc     <= 16'h0000;
        end else begin
            if (w_lvbl_rise) r_crc_acc <= 16'hFFFF;
            else if (w_push) r_crc_acc <= crc16_step(r_crc_acc, w_entry[DATA_W-1:0]);
            if (w_done) r_crc <= r_crc_acc;
        end
    end

    assign crc = r_crc;
`else
    assign crc = 16'h0000;
`endif

    assign fb_addr    = r_fb_addr;
    assign fb_din     = r_fb_din;
    assign fb_we      = r_fb_we;
    assign frame_done = r_frame_done;
    assign ovf        = r_ovf;
    assign hlen       = r_hlen;
    assign vlen       = r_vlen;
    assign busy       = r_armed | r_pending | ~w_empty | r_fb_we;

endmodule
